// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the sync_fifo_prog family.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty, count and flush.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic                            flush,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  wr_accept;
    logic                  rd_accept;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CW'(AF_THRESH));
    assign almostempty = (count <= CW'(AE_THRESH));

    // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
    assign wr_accept = !flush && wr_en && (!full || rd_en);
    assign rd_accept = !flush && rd_en && !empty;

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : rd_data;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= rd_data;
        end
    end
`endif

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock synchronous FIFO; next generation of the team's fixed 16-bit FIFO. Adds:
- configurable depth, including non-power-of-2 depths
- programmable almost-full / almost-empty thresholds
- an occupancy count output
- a synchronous flush
It sits between a producer and a consumer in the same clock domain and keeps the existing handshake/status signal set, so current benches and monitors carry over.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1)
- FIFO_DEPTH, 8, number of entries (>=2; any integer, not restricted to powers of 2)
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- flush  in  1  synchronous clear of contents
- data_out  out  FIFO_WIDTH  read data
- wr_ack  out  1  registered: previous-cycle write accepted
- overflow  out  1  registered: previous-cycle write rejected (FIFO full)
- underflow  out  1  registered: previous-cycle read rejected (FIFO empty)
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almostfull  out  1  count >= AF_THRESH
- almostempty  out  1  count <= AE_THRESH
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous; takes effect mid-operation):
  - wr_ptr, rd_ptr, count = 0
  - data_out = 0; wr_ack, overflow, underflow = 0
  - empty = 1, almostempty = 1, full = 0, almostfull = 0 (for AF_THRESH >= 1)
  - memory contents are not reset
- Pointers: range 0..FIFO_DEPTH-1; increment wraps FIFO_DEPTH-1 -> 0 explicitly (no reliance on binary overflow).
- Status outputs full, empty, almostfull, almostempty and count are combinational decodes of the count register. They change the cycle after the accepted op.
- Write accepted: wr_en && (!full || rd_en):
  - data_in is stored at wr_ptr; wr_ptr advances
  - wr_ack = 1 next cycle
  - otherwise, if wr_en is high: overflow = 1 next cycle
  - wr_ack and overflow are each cleared every cycle they are not set
- Read accepted: rd_en && !empty:
  - mem[rd_ptr] is registered into data_out (1-cycle latency); rd_ptr advances
  - otherwise, if rd_en is high: underflow = 1 next cycle
  - data_out holds its value when no read is accepted
- Simultaneous rd_en && wr_en:
  - full: both accepted, count unchanged, no overflow
  - empty: write accepted, read rejected with underflow = 1; the new word is not bypassed to data_out
  - otherwise: both accepted, count unchanged
- count update: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds FIFO_DEPTH or drops below 0.
- flush = 1:
  - overrides wr_en and rd_en: pointers and count go to 0 next cycle
  - wr_ack, overflow, underflow = 0 next cycle
  - data_out holds
- No FSM beyond the pointer/count state; all flag registers are single-cycle pulses per request.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty
  - rd_en acts as acknowledge/pop with 0-cycle latency
  - underflow rules are unchanged
- Undefined: standard mode, with registered data_out and 1-cycle read latency as above.

Decomposition:
- Package fifo_pkg holds:
  - default constants FIFO_WIDTH_DEF = 16, FIFO_DEPTH_DEF = 8
  - typedef struct fifo_status_t {full, empty, almostfull, almostempty, overflow, underflow, wr_ack}, for the bench scoreboard and monitor
- Natural sub-module fifo_mem: a parametrised simple dual-port register array (one write port, one async-read port). Pointer, count and flag logic stays in sync_fifo_prog.

Test Plan:
- Reset then fill: DEPTH=8, AF=7, AE=1; write 0x0001..0x0008 on consecutive cycles -> 8 wr_acks; almostfull high from count=7; full high at count=8; a 9th write gives overflow=1 and wr_ack=0.
- Drain: read 9 times -> data_out 0x0001..0x0008 in order, one cycle after each rd_en; 9th read gives underflow=1; empty=1, almostempty=1, count=0.
- Simultaneous: full FIFO with rd_en=wr_en=1 and data_in=0xBEEF -> count stays 8, no overflow; 0xBEEF emerges after 7 more reads. Empty FIFO with both high -> underflow=1, count=1.
- Wrap and non-power-of-2: DEPTH=5; 12 interleaved write/read pairs -> order preserved across 2+ pointer wraps; full at count=5.
- Flush and reset: count=4 with flush=1 and wr_en=1 -> next cycle count=0, empty=1, wr_ack=0. Assert rst_n low mid-burst, asynchronously between edges -> outputs go to reset values immediately.
- FIFO_FWFT_EN: write 0x00AA to an empty FIFO -> data_out=0x00AA the cycle after the write, before any rd_en; rd_en pops it with count going 1->0.
